// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite payload types, response codes and arbiter FSM state encodings.
package axi_lite_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;
  typedef logic [1:0]  resp_t;

  localparam resp_t OKAY   = 2'b00;
  localparam resp_t SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bundle; master drives requests, slave drives readies and responses.
interface axi_lite_if;
  import axi_lite_pkg::*;
  logic  awvalid, awready;
  addr_t awaddr;
  logic  wvalid, wready;
  data_t wdata;
  strb_t wstrb;
  logic  bvalid, bready;
  resp_t bresp;
  logic  arvalid, arready;
  addr_t araddr;
  logic  rvalid, rready;
  data_t rdata;
  resp_t rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_rr_sel.sv
// Two-requester round-robin selector; the last-grant pointer moves only on completion.
module axi_lite_rr_sel #(
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic       aclk,
  input  logic       areset_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_idx,
  output logic       gnt_idx
);
  logic last_q, last_d;

  always_comb begin
    last_d  = upd ? upd_idx : last_q;
    gnt_idx = (&req) ? ~last_q : req[1];
  end

  // Seeding "last" with the other master makes FIRST_PRIO win the first contention.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) last_q <= ~FIRST_PRIO;
    else           last_q <= last_d;
  end
endmodule

// File: rtl/axi_lite_rr_arbiter.sv
// 2:1 AXI4-Lite arbiter with independent round-robin write and read channels,
// registered grant and combinational forwarding while a transaction owns the slave.
module axi_lite_rr_arbiter
  import axi_lite_pkg::*;
#(
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic        aclk,
  input  logic        areset_n,
  axi_lite_if.slave   s_axi_lite0,
  axi_lite_if.slave   s_axi_lite1,
  axi_lite_if.master  m_axi_lite,
  output logic        wr_owner,
  output logic        rd_owner
);
  logic [1:0] up_awvalid, up_wvalid, up_bready, up_arvalid, up_rready;
  logic [1:0] up_awready, up_wready, up_bvalid, up_arready, up_rvalid;
  addr_t      up_awaddr [2];
  addr_t      up_araddr [2];
  data_t      up_wdata  [2];
  strb_t      up_wstrb  [2];

  assign up_awvalid = {s_axi_lite1.awvalid, s_axi_lite0.awvalid};
  assign up_wvalid  = {s_axi_lite1.wvalid,  s_axi_lite0.wvalid};
  assign up_bready  = {s_axi_lite1.bready,  s_axi_lite0.bready};
  assign up_arvalid = {s_axi_lite1.arvalid, s_axi_lite0.arvalid};
  assign up_rready  = {s_axi_lite1.rready,  s_axi_lite0.rready};
  assign up_awaddr[0] = s_axi_lite0.awaddr;
  assign up_awaddr[1] = s_axi_lite1.awaddr;
  assign up_araddr[0] = s_axi_lite0.araddr;
  assign up_araddr[1] = s_axi_lite1.araddr;
  assign up_wdata[0]  = s_axi_lite0.wdata;
  assign up_wdata[1]  = s_axi_lite1.wdata;
  assign up_wstrb[0]  = s_axi_lite0.wstrb;
  assign up_wstrb[1]  = s_axi_lite1.wstrb;

  wr_state_e wr_st_q, wr_st_d;
  rd_state_e rd_st_q, rd_st_d;
  logic      wr_own_q, wr_own_d, rd_own_q, rd_own_d;
  logic      aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic      wr_sel, rd_sel, wr_cmpl, rd_cmpl;
  logic      m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;

  axi_lite_rr_sel #(.FIRST_PRIO(FIRST_PRIO)) u_wr_sel (
    .aclk(aclk), .areset_n(areset_n), .req(up_awvalid),
    .upd(wr_cmpl), .upd_idx(wr_own_q), .gnt_idx(wr_sel)
  );

  axi_lite_rr_sel #(.FIRST_PRIO(FIRST_PRIO)) u_rd_sel (
    .aclk(aclk), .areset_n(areset_n), .req(up_arvalid),
    .upd(rd_cmpl), .upd_idx(rd_own_q), .gnt_idx(rd_sel)
  );

  // Only awvalid requests a write; a lone early wvalid waits untouched.
  always_comb begin
    wr_st_d    = wr_st_q;
    wr_own_d   = wr_own_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    up_awready = '0;
    up_wready  = '0;
    up_bvalid  = '0;
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    wr_cmpl    = 1'b0;
    case (wr_st_q)
      W_IDLE: if (|up_awvalid) begin
        wr_st_d   = W_XFER;
        wr_own_d  = wr_sel;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end
      W_XFER: begin
        m_awvalid            = up_awvalid[wr_own_q] & ~aw_done_q;
        m_wvalid             = up_wvalid[wr_own_q] & ~w_done_q;
        up_awready[wr_own_q] = m_axi_lite.awready & ~aw_done_q;
        up_wready[wr_own_q]  = m_axi_lite.wready & ~w_done_q;
        aw_done_d            = aw_done_q | (m_awvalid & m_axi_lite.awready);
        w_done_d             = w_done_q | (m_wvalid & m_axi_lite.wready);
        if (aw_done_d && w_done_d) wr_st_d = W_RESP;
      end
      W_RESP: begin
        m_bready            = up_bready[wr_own_q];
        up_bvalid[wr_own_q] = m_axi_lite.bvalid;
        if (m_axi_lite.bvalid && m_bready) begin
          wr_st_d = W_IDLE;
          wr_cmpl = 1'b1;
        end
      end
      default: wr_st_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_st_d    = rd_st_q;
    rd_own_d   = rd_own_q;
    up_arready = '0;
    up_rvalid  = '0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    rd_cmpl    = 1'b0;
    case (rd_st_q)
      R_IDLE: if (|up_arvalid) begin
        rd_st_d  = R_ADDR;
        rd_own_d = rd_sel;
      end
      R_ADDR: begin
        m_arvalid            = up_arvalid[rd_own_q];
        up_arready[rd_own_q] = m_axi_lite.arready;
        if (m_arvalid && m_axi_lite.arready) rd_st_d = R_DATA;
      end
      R_DATA: begin
        m_rready            = up_rready[rd_own_q];
        up_rvalid[rd_own_q] = m_axi_lite.rvalid;
        if (m_axi_lite.rvalid && m_rready) begin
          rd_st_d = R_IDLE;
          rd_cmpl = 1'b1;
        end
      end
      default: rd_st_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_st_q   <= W_IDLE;
      rd_st_q   <= R_IDLE;
      wr_own_q  <= 1'b0;
      rd_own_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      wr_st_q   <= wr_st_d;
      rd_st_q   <= rd_st_d;
      wr_own_q  <= wr_own_d;
      rd_own_q  <= rd_own_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign m_axi_lite.awvalid = m_awvalid;
  assign m_axi_lite.awaddr  = up_awaddr[wr_own_q];
  assign m_axi_lite.wvalid  = m_wvalid;
  assign m_axi_lite.wdata   = up_wdata[wr_own_q];
  assign m_axi_lite.wstrb   = up_wstrb[wr_own_q];
  assign m_axi_lite.bready  = m_bready;
  assign m_axi_lite.arvalid = m_arvalid;
  assign m_axi_lite.araddr  = up_araddr[rd_own_q];
  assign m_axi_lite.rready  = m_rready;

  assign s_axi_lite0.awready = up_awready[0];
  assign s_axi_lite1.awready = up_awready[1];
  assign s_axi_lite0.wready  = up_wready[0];
  assign s_axi_lite1.wready  = up_wready[1];
  assign s_axi_lite0.bvalid  = up_bvalid[0];
  assign s_axi_lite1.bvalid  = up_bvalid[1];
  assign s_axi_lite0.arready = up_arready[0];
  assign s_axi_lite1.arready = up_arready[1];
  assign s_axi_lite0.rvalid  = up_rvalid[0];
  assign s_axi_lite1.rvalid  = up_rvalid[1];

  // Response payload is steered to the owner only; the other side reads idle values.
  assign s_axi_lite0.bresp = (wr_own_q == 1'b0) ? m_axi_lite.bresp : OKAY;
  assign s_axi_lite1.bresp = (wr_own_q == 1'b1) ? m_axi_lite.bresp : OKAY;
  assign s_axi_lite0.rresp = (rd_own_q == 1'b0) ? m_axi_lite.rresp : OKAY;
  assign s_axi_lite1.rresp = (rd_own_q == 1'b1) ? m_axi_lite.rresp : OKAY;
  assign s_axi_lite0.rdata = (rd_own_q == 1'b0) ? m_axi_lite.rdata : '0;
  assign s_axi_lite1.rdata = (rd_own_q == 1'b1) ? m_axi_lite.rdata : '0;

  assign wr_owner = wr_own_q;
  assign rd_owner = rd_own_q;
endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Directed bench: two upstream masters and the downstream slave are driven by hand.
module tb_axi_lite_rr_arbiter;
  import axi_lite_pkg::*;

  logic aclk, areset_n;
  logic wr_owner, rd_owner;
  int   checks, failures;
  int   aw_hs_cnt, w_hs_cnt;
  int   aw_base, w_base;

  axi_lite_if m0 ();
  axi_lite_if m1 ();
  axi_lite_if s ();

  axi_lite_rr_arbiter #(.FIRST_PRIO(1'b0)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .s_axi_lite0(m0), .s_axi_lite1(m1), .m_axi_lite(s),
    .wr_owner(wr_owner), .rd_owner(rd_owner)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    aw_hs_cnt = 0;
    w_hs_cnt  = 0;
  end
  always @(posedge aclk) begin
    if (s.awvalid && s.awready) aw_hs_cnt <= aw_hs_cnt + 1;
    if (s.wvalid && s.wready)   w_hs_cnt  <= w_hs_cnt + 1;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    areset_n = 1'b0;
    {m0.awvalid, m0.wvalid, m0.bready, m0.arvalid, m0.rready} = '0;
    {m1.awvalid, m1.wvalid, m1.bready, m1.arvalid, m1.rready} = '0;
    m0.awaddr = '0; m0.wdata = '0; m0.wstrb = '0; m0.araddr = '0;
    m1.awaddr = '0; m1.wdata = '0; m1.wstrb = '0; m1.araddr = '0;
    {s.awready, s.wready, s.bvalid, s.arready, s.rvalid} = '0;
    s.bresp = OKAY; s.rresp = OKAY; s.rdata = '0;

    // Reset state
    tick(); tick();
    chk("rst_s_awvalid", s.awvalid, 0);
    chk("rst_s_wvalid",  s.wvalid, 0);
    chk("rst_s_arvalid", s.arvalid, 0);
    chk("rst_s_bready",  s.bready, 0);
    chk("rst_m0_bvalid", m0.bvalid, 0);
    chk("rst_m1_rvalid", m1.rvalid, 0);
    areset_n = 1'b1;
    s.awready = 1'b1; s.wready = 1'b1; s.arready = 1'b1;

    // Single write from M0
    m0.awvalid = 1'b1; m0.awaddr = 32'h10; m0.wvalid = 1'b1;
    m0.wdata = 32'hDEAD_BEEF; m0.wstrb = 4'hF; m0.bready = 1'b1;
    #1;
    chk("w1_aw_registered", s.awvalid, 0);
    chk("w1_m0_held_off", m0.awready, 0);
    tick();
    chk("w1_s_awvalid", s.awvalid, 1);
    chk("w1_s_awaddr", s.awaddr, 32'h10);
    chk("w1_s_wdata", s.wdata, 32'hDEAD_BEEF);
    chk("w1_s_wstrb", s.wstrb, 4'hF);
    chk("w1_m0_awready", m0.awready, 1);
    chk("w1_m1_awready", m1.awready, 0);
    chk("w1_wr_owner", wr_owner, 0);
    tick();
    m0.awvalid = 1'b0; m0.wvalid = 1'b0;
    s.bvalid = 1'b1; s.bresp = OKAY;
    #1;
    chk("w1_s_awvalid_done", s.awvalid, 0);
    chk("w1_m0_bvalid", m0.bvalid, 1);
    chk("w1_m0_bresp", m0.bresp, OKAY);
    chk("w1_m1_bvalid", m1.bvalid, 0);
    chk("w1_s_bready", s.bready, 1);
    tick();
    s.bvalid = 1'b0;
    #1;
    chk("w1_m0_bvalid_end", m0.bvalid, 0);

    // Read contention right after reset: M0 first, then M1
    areset_n = 1'b0;
    tick();
    areset_n = 1'b1;
    m0.arvalid = 1'b1; m0.araddr = 32'h100; m0.rready = 1'b1;
    m1.arvalid = 1'b1; m1.araddr = 32'h200; m1.rready = 1'b1;
    #1;
    chk("rc_ar_registered", s.arvalid, 0);
    tick();
    chk("rc0_s_arvalid", s.arvalid, 1);
    chk("rc0_s_araddr", s.araddr, 32'h100);
    chk("rc0_rd_owner", rd_owner, 0);
    chk("rc0_m0_arready", m0.arready, 1);
    chk("rc0_m1_arready", m1.arready, 0);
    tick();
    m0.arvalid = 1'b0;
    s.rvalid = 1'b1; s.rdata = 32'hCAFE_F00D; s.rresp = SLVERR;
    #1;
    chk("rc0_m0_rvalid", m0.rvalid, 1);
    chk("rc0_m0_rdata", m0.rdata, 32'hCAFE_F00D);
    chk("rc0_m0_rresp", m0.rresp, SLVERR);
    chk("rc0_m1_rvalid", m1.rvalid, 0);
    tick();
    s.rvalid = 1'b0;
    #1;
    chk("rc_gap_s_arvalid", s.arvalid, 0);
    tick();
    chk("rc1_s_arvalid", s.arvalid, 1);
    chk("rc1_s_araddr", s.araddr, 32'h200);
    chk("rc1_rd_owner", rd_owner, 1);
    chk("rc1_m1_arready", m1.arready, 1);
    tick();
    m1.arvalid = 1'b0;
    s.rvalid = 1'b1; s.rdata = 32'h1234_5678; s.rresp = OKAY;
    #1;
    chk("rc1_m1_rvalid", m1.rvalid, 1);
    chk("rc1_m1_rdata", m1.rdata, 32'h1234_5678);
    chk("rc1_m0_rvalid", m0.rvalid, 0);
    tick();
    s.rvalid = 1'b0;

    // Fairness: 4 writes each, both always requesting
    m0.awvalid = 1'b1; m0.awaddr = 32'h40; m0.wvalid = 1'b1; m0.wdata = 32'hA0; m0.bready = 1'b1;
    m1.awvalid = 1'b1; m1.awaddr = 32'h80; m1.wvalid = 1'b1; m1.wdata = 32'hB0; m1.bready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("fair_owner", wr_owner, k % 2);
      chk("fair_awaddr", s.awaddr, (k % 2) ? 32'h80 : 32'h40);
      tick();
      s.bvalid = 1'b1;
      tick();
      s.bvalid = 1'b0;
      if (k == 6) begin m0.awvalid = 1'b0; m0.wvalid = 1'b0; end
      if (k == 7) begin m1.awvalid = 1'b0; m1.wvalid = 1'b0; end
    end

    // W before AW from M1; AW then stalled so W completes first
    aw_base = aw_hs_cnt; w_base = w_hs_cnt;
    m1.wvalid = 1'b1; m1.wdata = 32'h55AA; m1.wstrb = 4'h3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wfirst_no_wvalid", s.wvalid, 0);
      chk("wfirst_m1_wready", m1.wready, 0);
    end
    s.awready = 1'b0;
    m1.awvalid = 1'b1; m1.awaddr = 32'h30;
    #1;
    chk("wfirst_aw_registered", s.awvalid, 0);
    tick();
    chk("wfirst_s_wvalid", s.wvalid, 1);
    chk("wfirst_s_awvalid", s.awvalid, 1);
    chk("wfirst_wr_owner", wr_owner, 1);
    chk("wfirst_s_wstrb", s.wstrb, 4'h3);
    tick();
    chk("wfirst_w_masked", s.wvalid, 0);
    chk("wfirst_m1_wready_masked", m1.wready, 0);
    chk("wfirst_aw_pending", s.awvalid, 1);
    s.awready = 1'b1;
    #1;
    chk("wfirst_m1_awready", m1.awready, 1);
    tick();
    m1.awvalid = 1'b0; m1.wvalid = 1'b0;
    s.bvalid = 1'b1; s.bresp = SLVERR;
    #1;
    chk("wfirst_m1_bvalid", m1.bvalid, 1);
    chk("wfirst_m1_bresp", m1.bresp, SLVERR);
    chk("wfirst_m0_bvalid", m0.bvalid, 0);
    tick();
    s.bvalid = 1'b0; s.bresp = OKAY;
    chk("wfirst_aw_count", aw_hs_cnt - aw_base, 1);
    chk("wfirst_w_count", w_hs_cnt - w_base, 1);

    // Concurrent write (M0) and read (M1) of 0x20
    m0.awvalid = 1'b1; m0.awaddr = 32'h20; m0.wvalid = 1'b1; m0.wdata = 32'h1122_3344;
    m1.arvalid = 1'b1; m1.araddr = 32'h20;
    tick();
    chk("cc_wr_owner", wr_owner, 0);
    chk("cc_rd_owner", rd_owner, 1);
    chk("cc_s_awvalid", s.awvalid, 1);
    chk("cc_s_arvalid", s.arvalid, 1);
    chk("cc_s_araddr", s.araddr, 32'h20);
    chk("cc_m0_arready", m0.arready, 0);
    chk("cc_m1_awready", m1.awready, 0);
    tick();
    m0.awvalid = 1'b0; m0.wvalid = 1'b0; m1.arvalid = 1'b0;
    s.bvalid = 1'b1; s.rvalid = 1'b1; s.rdata = 32'h1122_3344;
    #1;
    chk("cc_m0_bvalid", m0.bvalid, 1);
    chk("cc_m1_rvalid", m1.rvalid, 1);
    chk("cc_m1_rdata", m1.rdata, 32'h1122_3344);
    chk("cc_m0_rvalid", m0.rvalid, 0);
    chk("cc_m1_bvalid", m1.bvalid, 0);
    tick();
    s.bvalid = 1'b0; s.rvalid = 1'b0;

    // Reset while B is pending; read request held through reset
    m0.awvalid = 1'b1; m0.awaddr = 32'h44; m0.wvalid = 1'b1;
    tick();
    tick();
    m0.awvalid = 1'b0; m0.wvalid = 1'b0;
    s.bvalid = 1'b1;
    #1;
    chk("mr_m0_bvalid_before", m0.bvalid, 1);
    areset_n = 1'b0;
    m1.arvalid = 1'b1; m1.araddr = 32'h60;
    #1;
    chk("mr_m0_bvalid_async", m0.bvalid, 0);
    chk("mr_s_bready_async", s.bready, 0);
    chk("mr_s_arvalid_async", s.arvalid, 0);
    tick();
    areset_n = 1'b1;
    #1;
    chk("mr_no_early_grant", s.arvalid, 0);
    chk("mr_m0_bvalid_rel", m0.bvalid, 0);
    tick();
    chk("mr_first_grant", s.arvalid, 1);
    chk("mr_m0_bvalid_after", m0.bvalid, 0);
    tick();
    m1.arvalid = 1'b0;
    s.bvalid = 1'b0;
    s.rvalid = 1'b1;
    tick();
    s.rvalid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_lite_rr_arbiter.md
AXI_LITE_RR_ARBITER -- requirements
Module: axi_lite_rr_arbiter

Interface
REQ-001 SHALL have parameter FIRST_PRIO, default 0, giving the master favoured on the first contention after reset.
REQ-002 SHALL have port aclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port areset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port s_axi_lite0, axi_lite_if.slave, AXI4-Lite bundle: faces master 0.
REQ-005 SHALL have port s_axi_lite1, axi_lite_if.slave, AXI4-Lite bundle: faces master 1.
REQ-006 SHALL have port m_axi_lite, axi_lite_if.master, AXI4-Lite bundle: faces the shared slave.
REQ-007 SHALL have ports wr_owner and rd_owner, outputs, 1 bit each: index of the current write/read grant, valid while busy.

Function
REQ-008 SHALL keep independent write and read arbiters, so one master may write while the other reads.
REQ-009 SHALL use write FSM states W_IDLE, W_XFER, W_RESP.
REQ-010 Write FSM, W_IDLE to W_XFER: on a registered grant when any awvalid is high.
REQ-011 Write FSM, W_XFER to W_RESP: when the granted AW and W handshakes have both completed, in either order or the same cycle.
REQ-012 Write FSM, W_RESP to W_IDLE: on the m bvalid&&bready handshake.
REQ-013 SHALL use read FSM states R_IDLE, R_ADDR, R_DATA.
REQ-014 Read FSM, R_IDLE to R_ADDR: on grant when any arvalid is high.
REQ-015 Read FSM, R_ADDR to R_DATA: on the m arvalid&&arready handshake.
REQ-016 Read FSM, R_DATA to R_IDLE: on the m rvalid&&rready handshake.
REQ-017 Grant SHALL be round-robin: with both requesting, grant the master not granted last; with one requesting, grant it.
REQ-018 The last-grant pointer SHALL update only on transaction completion (B or R handshake).
REQ-019 Grant SHALL be registered: downstream awvalid/arvalid rises exactly 1 cycle after upstream valid is seen in IDLE.
REQ-020 In W_XFER/R_ADDR, the granted master's AW/W/AR payload and valid SHALL be forwarded combinationally, and its ready returned combinationally.
REQ-021 Downstream awvalid SHALL be masked once AW completes; wvalid SHALL be masked once W completes, using flags aw_done/w_done cleared on entry to W_XFER.
REQ-022 bresp/bvalid and rdata/rresp/rvalid SHALL route only to the owner; the owner's bready/rready SHALL route downstream.
REQ-023 The non-owner SHALL see awready, wready, arready, bvalid and rvalid all 0 at all times.
REQ-024 Requests arriving while the arbiter is busy SHALL be held off (ready=0), not dropped; AXI valid-stability is the master's duty.
REQ-025 A wvalid without awvalid SHALL NOT trigger arbitration.
REQ-026 No payload transformation: addr_t, data_t, strobe and resp SHALL pass bit-exact.

Reset
REQ-027 Asserting areset_n low SHALL asynchronously force the FSMs to W_IDLE/R_IDLE, aw_done=w_done=0, last-grant=~FIRST_PRIO, and all downstream valids and upstream readies/valids to 0.
REQ-028 Reset mid-transaction SHALL abandon that transaction; no response is forwarded after release.
REQ-029 After reset release, the first grant SHALL occur no earlier than the first rising edge with areset_n high.

Structure
REQ-030 addr_t, data_t, strb_t, resp_t and OKAY/SLVERR constants SHALL come from axi_lite_pkg; the FSM state enums SHALL be added there.
REQ-031 The 2-requester round-robin logic SHALL be one sub-module, axi_lite_rr_sel, instantiated twice (write and read).
REQ-032 Target size SHALL be about 200-300 lines of RTL.

Verification
REQ-033 Single write: M0 writes awaddr=0x10, wdata=0xDEAD_BEEF -> downstream AW 1 cycle later, M0 gets bresp=OKAY, M1 sees no handshake.
REQ-034 Contention: M0 and M1 both raise arvalid at cycle 0 after reset with FIRST_PRIO=0 -> M0 is served first; M1's AR is forwarded on the cycle after M0's R handshake plus 1.
REQ-035 Fairness: both masters issue 4 back-to-back writes -> grants strictly alternate M0, M1, M0, M1, ...
REQ-036 W before AW: M1 drives wvalid 3 cycles before awvalid -> no grant until awvalid; exactly one W and one AW reach the slave.
REQ-037 Concurrency: M0 writes 0x20 while M1 reads 0x20 -> both proceed in parallel; wr_owner=0, rd_owner=1.
REQ-038 Reset mid-W_RESP: areset_n pulsed low while bvalid is pending -> all valids 0 immediately, no bvalid to M0 after release.
